// File: rtl/hdr_dispatch_pkg.sv
// rtl/hdr_dispatch_pkg.sv - shared types and constants for the HDR command dispatcher
// Contents: state_e FSM encoding, response error codes, CMD_ATTR values,
//           attr_supported() helper used by the decode step.
package hdr_dispatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_RUN_CCC = 3'd3,
        ST_RUN_DDR = 3'd4,
        ST_RESP    = 3'd5,
        ST_EXIT    = 3'd6
    } state_e;

    localparam logic [3:0] RESP_OK         = 4'd0;
    localparam logic [3:0] RESP_ENGINE_ERR = 4'd1;
    localparam logic [3:0] RESP_TIMEOUT    = 4'd4;
    localparam logic [3:0] RESP_UNSUPP     = 4'd8;

    localparam logic [2:0] CMD_ATTR_REGULAR   = 3'd0;
    localparam logic [2:0] CMD_ATTR_IMMEDIATE = 3'd1;

    function automatic logic attr_supported(input logic [2:0] attr);
        return (attr == CMD_ATTR_REGULAR) || (attr == CMD_ATTR_IMMEDIATE);
    endfunction

endpackage

// File: rtl/hdr_cmd_dispatcher_if.sv
// rtl/hdr_cmd_dispatcher_if.sv - dispatcher bus: regfile fetch, engine handshakes, response, exit
// Modports: master = dispatcher side (drives o_* signals),
//           slave  = environment side (regfile, engines, response consumer, exit generator).
interface hdr_cmd_dispatcher_if #(
    parameter int ADDR_W = 8
);
    logic              i_hdr_en;
    logic              o_regf_rd_en;
    logic [ADDR_W-1:0] o_regf_addr;
    logic              i_regf_CP;
    logic [2:0]        i_regf_CMD_ATTR;
    logic              i_regf_TOC;
    logic [4:0]        i_regf_DEV_INDEX;
    logic              o_ccc_en;
    logic              i_ccc_done;
    logic              o_ddr_en;
    logic              i_ddr_done;
    logic              i_engine_err;
    logic              o_resp_valid;
    logic              i_resp_ready;
    logic [3:0]        o_resp_err;
    logic [4:0]        o_resp_dev_index;
    logic              o_exit_en;
    logic              i_exit_done;
    logic              o_hdr_done;

    modport master (
        input  i_hdr_en, i_regf_CP, i_regf_CMD_ATTR, i_regf_TOC, i_regf_DEV_INDEX,
               i_ccc_done, i_ddr_done, i_engine_err, i_resp_ready, i_exit_done,
        output o_regf_rd_en, o_regf_addr, o_ccc_en, o_ddr_en, o_resp_valid,
               o_resp_err, o_resp_dev_index, o_exit_en, o_hdr_done
    );

    modport slave (
        output i_hdr_en, i_regf_CP, i_regf_CMD_ATTR, i_regf_TOC, i_regf_DEV_INDEX,
               i_ccc_done, i_ddr_done, i_engine_err, i_resp_ready, i_exit_done,
        input  o_regf_rd_en, o_regf_addr, o_ccc_en, o_ddr_en, o_resp_valid,
               o_resp_err, o_resp_dev_index, o_exit_en, o_hdr_done
    );

endinterface

// File: rtl/hdr_cmd_dispatcher_watchdog.sv
// rtl/hdr_cmd_dispatcher_watchdog.sv - engine run-time watchdog (HDR_DISPATCH_WATCHDOG_EN builds only)
// Ports: clk, rst_n (async active-low), clear (restart count), enable (count this cycle),
//        expired (engine has been enabled for TIMEOUT_CYCLES cycles including this one).
`ifdef HDR_DISPATCH_WATCHDOG_EN
module dispatch_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    // Count is 0 on the first enabled cycle, so expiry lands on the TIMEOUT_CYCLES-th one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/hdr_cmd_dispatcher.sv
// rtl/hdr_cmd_dispatcher.sv - per-command sequencer between descriptor regfile and HDR-DDR engines
// Ports: i_sys_clk, i_sys_rst (async active-low), bus (hdr_cmd_dispatcher_if.master):
//        descriptor fetch (rd_en/addr + CP/CMD_ATTR/TOC/DEV_INDEX), CCC and DDR engine
//        enable/done/err, response valid/ready/err/dev_index, HDR exit request, hdr_done pulse.
// Optional macro HDR_DISPATCH_WATCHDOG_EN adds an engine timeout (response err 4).
module hdr_cmd_dispatcher
    import hdr_dispatch_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 8,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    hdr_cmd_dispatcher_if.master  bus
);
    localparam int PTR_W = (QUEUE_DEPTH > 2) ? $clog2(QUEUE_DEPTH) : 1;

    state_e           state, state_d;
    logic [PTR_W-1:0] ptr;
    logic             toc_q;
    logic [4:0]       dev_q;
    logic [3:0]       err_q, err_d;
    logic             ptr_adv;
    logic             hdr_done_q;
    logic             run_st;
    logic             wd_expired;

    assign run_st = (state == ST_RUN_CCC) || (state == ST_RUN_DDR);

`ifdef HDR_DISPATCH_WATCHDOG_EN
    dispatch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (i_sys_clk),
        .rst_n   (i_sys_rst),
        .clear   (state == ST_DECODE),
        .enable  (run_st),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d = state;
        err_d   = err_q;
        ptr_adv = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.i_hdr_en) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (!attr_supported(bus.i_regf_CMD_ATTR)) begin
                    state_d = ST_RESP;
                    err_d   = RESP_UNSUPP;
                end else if (bus.i_regf_CP) begin
                    state_d = ST_RUN_CCC;
                end else begin
                    state_d = ST_RUN_DDR;
                end
            end
            // Done is checked before expiry so a completion on the last allowed cycle counts.
            ST_RUN_CCC: begin
                if (bus.i_ccc_done) begin
                    state_d = ST_RESP;
                    err_d   = bus.i_engine_err ? RESP_ENGINE_ERR : RESP_OK;
                end else if (wd_expired) begin
                    state_d = ST_RESP;
                    err_d   = RESP_TIMEOUT;
                end
            end
            ST_RUN_DDR: begin
                if (bus.i_ddr_done) begin
                    state_d = ST_RESP;
                    err_d   = bus.i_engine_err ? RESP_ENGINE_ERR : RESP_OK;
                end else if (wd_expired) begin
                    state_d = ST_RESP;
                    err_d   = RESP_TIMEOUT;
                end
            end
            ST_RESP: begin
                if (bus.i_resp_ready) begin
                    ptr_adv = 1'b1;
                    state_d = (toc_q || !bus.i_hdr_en) ? ST_EXIT : ST_FETCH;
                end
            end
            ST_EXIT: begin
                if (bus.i_exit_done) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            toc_q      <= 1'b0;
            dev_q      <= '0;
            err_q      <= RESP_OK;
            hdr_done_q <= 1'b0;
        end else begin
            state      <= state_d;
            err_q      <= err_d;
            hdr_done_q <= (state == ST_EXIT) && bus.i_exit_done;
            if (state == ST_DECODE) begin
                toc_q <= bus.i_regf_TOC;
                dev_q <= bus.i_regf_DEV_INDEX;
            end
            if (ptr_adv) begin
                ptr <= (ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : ptr + 1'b1;
            end
        end
    end

    assign bus.o_regf_rd_en     = (state == ST_FETCH);
    assign bus.o_regf_addr      = ADDR_W'(ptr);
    assign bus.o_ccc_en         = (state == ST_RUN_CCC);
    assign bus.o_ddr_en         = (state == ST_RUN_DDR);
    assign bus.o_resp_valid     = (state == ST_RESP);
    assign bus.o_resp_err       = err_q;
    assign bus.o_resp_dev_index = dev_q;
    assign bus.o_exit_en        = (state == ST_EXIT);
    assign bus.o_hdr_done       = hdr_done_q;

endmodule
